usrt_tx_fifo: RTL and testbench
===============================

// Module: usrt_tx_fifo
// PURPOSE
//  Synchronous (USRT) transmitter with an input byte FIFO. Feeds the USRT receiver
//  over a shared clock: serialises queued bytes as frames of 1 start bit (0),
//  8 data bits LSB first, then STOP_BITS stop bits (1). Line idles high.
//  The line is driven on the rising edge of i_Clock; the receiver samples it on the falling edge.
// PARAMETERS
//  FIFO_DEPTH  8  byte entries; power of 2, >= 2
//  STOP_BITS   1  stop bits per frame; legal values 1 or 2
// PORTS
//  i_Clock        in   1   single clock; all logic on posedge
//  i_Reset        in   1   synchronous, active-high reset
//  i_Tx_DV        in   1   write strobe; byte accepted on posedge when i_Tx_DV && o_Tx_Ready
//  i_Tx_Byte      in   8   byte to queue
//  o_Tx_Ready     out  1   FIFO not full
//  o_Fifo_Count   out  $clog2(FIFO_DEPTH)+1   queued bytes, excluding the frame in flight
//  o_Tx_Serial    out  1   serial line
//  o_Tx_Active    out  1   a frame is being driven (start bit through last stop bit)
//  o_Tx_Done      out  1   1-cycle pulse in the cycle the last stop bit is driven
//  o_Overflow     out  1   1-cycle pulse when i_Tx_DV arrives while full; the byte is dropped
// BEHAVIOUR
//  Reset (sync): FIFO emptied, state = IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0,
//   o_Overflow=0, o_Fifo_Count=0, o_Tx_Ready=1. Reset mid-frame aborts the frame:
//   the line is high from the next cycle on, and the queued bytes are lost.
//  FIFO: o_Tx_Ready = !full, registered count. A write while full is dropped and pulses
//   o_Overflow, even if a pop happens in the same cycle. A simultaneous push and pop
//   (not full) leaves the count unchanged.
//  FSM states: IDLE, START, DATA, STOP. Transitions occur at posedge.
//   IDLE: line = 1. If the FIFO is non-empty, pop the head into the shift register,
//    drive 0 and go to START.
//   START: drive bit 0 of the shift register, bit index = 0, go to DATA.
//   DATA: drive the next bit; after bit 7 has been driven for one cycle, drive 1 and go to STOP.
//   STOP: hold 1 for STOP_BITS cycles. o_Tx_Done is high in the final stop cycle.
//    At the end of that cycle, if the FIFO is non-empty, pop and drive 0 (back-to-back,
//    no idle gap); otherwise go to IDLE.
//  Each line bit lasts exactly 1 cycle. A frame is 9+STOP_BITS cycles.
//  Latency: a write accepted at edge N into an empty FIFO with an idle FSM puts the
//   start bit on the line after edge N+1, so o_Fifo_Count is 1 for exactly one cycle.
//  o_Tx_Active is high for every start, data and stop cycle, and low in IDLE.
//  The bit index is 3 bits; the stop-bit counter is 1 bit. No wrap beyond bit 7.
//  FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//  Full and empty are derived from the count.
// STRUCTURE
//  Shared include usrt_defs.vh holds the frame constants (START_BIT=0, STOP_BIT=1,
//   DATA_BITS=8), which the receiver also uses, plus the state encodings
//   (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11).
//  Sub-module: usrt_sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH). Ports: push, pop, din, dout,
//   full, empty, count. Sync reset. dout is combinational from the head entry.
//  The top level holds the FSM, shift register, bit counter and stop counter.
// TESTING
//  1 Write 0xA5 when idle -> o_Tx_Serial from edge N+1 = 0,1,0,1,0,0,1,0,1,1;
//    o_Tx_Done pulses once, in the 10th bit cycle; the line then stays 1.
//  2 Write 0x00,0xFF,0x3C back-to-back -> 30 contiguous bit cycles, no idle gap;
//    a loopback USRT receiver on the same clock reports 0x00,0xFF,0x3C in order.
//  3 Hold the FSM busy and write 9 bytes with FIFO_DEPTH=8 -> count reaches 8, o_Tx_Ready=0,
//    the 9th write pulses o_Overflow and is dropped; the 8 queued bytes are sent in order.
//  4 At full, write in the same cycle as a pop -> the write is dropped, o_Overflow=1,
//    and the count goes 8 -> 7.
//  5 Assert i_Reset during data bit 3 of 0x5A -> line = 1 from the next cycle,
//    o_Tx_Active=0, count=0; a subsequent write of 0x81 transmits cleanly.
//  6 STOP_BITS=2, write 0xC3 -> a 11-cycle frame; o_Tx_Done pulses in the 11th cycle;
//    the loopback receiver reports 0xC3.

Source files
------------

// File: rtl/usrt_tx_fifo_pkg.sv
// Frame constants and FSM state encodings shared by the USRT
// transmitter and receiver.
package usrt_tx_fifo_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_DATA  = 2'b10;
  localparam logic [1:0] ST_STOP  = 2'b11;

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/usrt_sync_fifo.sv
// Synchronous FIFO, sync active-high reset, combinational head.
// Ports: i_push/i_pop strobes, i_din/o_dout data, o_full/o_empty/o_count.
module usrt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // Guard here too so a careless caller cannot corrupt the count.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/usrt_tx_fifo.sv
// USRT transmitter with a byte FIFO: start, 8 data LSB first, stop bits.
// Ports: i_Tx_DV/i_Tx_Byte in, o_Tx_Ready/o_Fifo_Count/o_Overflow, line outs.
module usrt_tx_fifo
  import usrt_tx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic                          o_Overflow
);

  logic [1:0] r_state;
  logic [7:0] r_shift;
  logic [2:0] r_idx;
  logic       r_stop_cnt;
  logic       r_serial;
  logic       r_done;
  logic       r_ovf;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_final_stop;
  logic [7:0] w_head;

  assign w_push = i_Tx_DV && !w_full;

  assign w_final_stop = (r_state == ST_STOP) &&
                        (r_stop_cnt == 1'(STOP_BITS - 1));

  // Pop from idle, or at the end of the last stop bit so
  // consecutive frames run with no idle gap.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || w_final_stop);

  usrt_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_Clock),
    .i_rst   (i_Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_Tx_Byte),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_Fifo_Count)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_stop_cnt <= 1'b0;
      r_serial   <= STOP_BIT;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_ovf  <= i_Tx_DV && w_full;
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_serial <= STOP_BIT;
          if (w_pop) begin
            r_shift  <= w_head;
            r_serial <= START_BIT;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          r_serial <= r_shift[0];
          r_shift  <= r_shift >> 1;
          r_idx    <= '0;
          r_state  <= ST_DATA;
        end
        ST_DATA: begin
          if (r_idx == LAST_IDX) begin
            r_serial   <= STOP_BIT;
            r_stop_cnt <= 1'b0;
            r_done     <= (STOP_BITS == 1);
            r_state    <= ST_STOP;
          end else begin
            r_serial <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_idx    <= r_idx + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_final_stop) begin
            if (w_pop) begin
              r_shift  <= w_head;
              r_serial <= START_BIT;
              r_state  <= ST_START;
            end else begin
              r_serial <= STOP_BIT;
              r_state  <= ST_IDLE;
            end
          end else begin
            // Entering the final stop cycle next.
            r_stop_cnt <= r_stop_cnt + 1'b1;
            r_serial   <= STOP_BIT;
            r_done     <= 1'b1;
          end
        end
        default: begin
          r_serial <= STOP_BIT;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_Tx_Ready  = !w_full;
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Active = (r_state != ST_IDLE);
  assign o_Tx_Done   = r_done;
  assign o_Overflow  = r_ovf;

endmodule

// File: tb/tb_usrt_tx_fifo.sv
// Directed bench for usrt_tx_fifo with 1 and 2 stop bits and a
// negedge-sampling loopback receiver on each line.
module tb_usrt_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv1, dv2;
  logic [7:0] byte1, byte2;
  logic       rdy1, rdy2;
  logic [3:0] cnt1, cnt2;
  logic       ser1, ser2;
  logic       act1, act2;
  logic       done1, done2;
  logic       ovf1, ovf2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] rxq1[$];
  logic [7:0] rxq2[$];

  always #5 clk = ~clk;

  usrt_tx_fifo #(.FIFO_DEPTH(8), .STOP_BITS(1)) dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv1), .i_Tx_Byte(byte1),
    .o_Tx_Ready(rdy1), .o_Fifo_Count(cnt1), .o_Tx_Serial(ser1),
    .o_Tx_Active(act1), .o_Tx_Done(done1), .o_Overflow(ovf1)
  );

  usrt_tx_fifo #(.FIFO_DEPTH(8), .STOP_BITS(2)) dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv2), .i_Tx_Byte(byte2),
    .o_Tx_Ready(rdy2), .o_Fifo_Count(cnt2), .o_Tx_Serial(ser2),
    .o_Tx_Active(act2), .o_Tx_Done(done2), .o_Overflow(ovf2)
  );

  int         r1_st, r1_n, r2_st, r2_n;
  logic [7:0] r1_sh, r2_sh;

  always @(negedge clk) begin
    if (rst) begin
      r1_st <= 0;
    end else if (r1_st == 0) begin
      if (ser1 == 1'b0) begin
        r1_st <= 1;
        r1_n  <= 0;
      end
    end else if (r1_st == 1) begin
      r1_sh[r1_n] <= ser1;
      r1_n <= r1_n + 1;
      if (r1_n == 7) r1_st <= 2;
    end else begin
      if (ser1 == 1'b1) rxq1.push_back(r1_sh);
      r1_st <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      r2_st <= 0;
    end else if (r2_st == 0) begin
      if (ser2 == 1'b0) begin
        r2_st <= 1;
        r2_n  <= 0;
      end
    end else if (r2_st == 1) begin
      r2_sh[r2_n] <= ser2;
      r2_n <= r2_n + 1;
      if (r2_n == 7) r2_st <= 2;
    end else begin
      if (ser2 == 1'b1) rxq2.push_back(r2_sh);
      r2_st <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  logic [7:0] t2 [3];
  logic [7:0] t3 [9];

  initial begin
    t2[0] = 8'h00; t2[1] = 8'hFF; t2[2] = 8'h3C;
    t3[0] = 8'h11;
    for (int i = 1; i < 9; i++) t3[i] = 8'(8'h20 + i);
    rst = 1'b1;
    dv1 = 1'b0; byte1 = '0;
    dv2 = 1'b0; byte2 = '0;
    tick(); tick();
    chk("rst_ser", ser1, 1);
    chk("rst_act", act1, 0);
    chk("rst_done", done1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_cnt", cnt1, 0);
    chk("rst_rdy", rdy1, 1);
    rst = 1'b0;
    tick();

    // 1: single byte 0xA5
    rxq1.delete();
    dv1 = 1'b1; byte1 = 8'hA5;
    tick();
    dv1 = 1'b0;
    chk("t1_cnt1", cnt1, 1);
    chk("t1_idle_ser", ser1, 1);
    chk("t1_idle_act", act1, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t1_bit%0d", k), ser1, fbit(8'hA5, k));
      chk($sformatf("t1_done%0d", k), done1, k == 9);
      chk($sformatf("t1_act%0d", k), act1, 1);
      if (k == 0) chk("t1_cnt0", cnt1, 0);
    end
    tick();
    chk("t1_after_ser", ser1, 1);
    chk("t1_after_act", act1, 0);
    chk("t1_after_done", done1, 0);
    tick(); tick();
    chk("t1_after2_ser", ser1, 1);
    chk("t1_rx_n", rxq1.size(), 1);
    if (rxq1.size() == 1) chk("t1_rx0", rxq1[0], 8'hA5);

    // 2: back-to-back 0x00, 0xFF, 0x3C
    rxq1.delete();
    dv1 = 1'b1; byte1 = t2[0];
    tick();
    for (int k = 0; k < 30; k++) begin
      dv1 = (k < 2);
      byte1 = (k == 0) ? t2[1] : t2[2];
      tick();
      chk($sformatf("t2_bit%0d", k), ser1, fbit(t2[k/10], k % 10));
      chk($sformatf("t2_act%0d", k), act1, 1);
    end
    dv1 = 1'b0;
    tick();
    chk("t2_after_ser", ser1, 1);
    chk("t2_after_act", act1, 0);
    tick(); tick();
    chk("t2_rx_n", rxq1.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < rxq1.size()) chk($sformatf("t2_rx%0d", i), rxq1[i], t2[i]);

    // 3/4: fill while busy, overflow without and with a pop
    rxq1.delete();
    dv1 = 1'b1; byte1 = t3[0];
    tick();
    dv1 = 1'b0;
    tick();
    for (int i = 1; i < 9; i++) begin
      dv1 = 1'b1; byte1 = t3[i];
      tick();
    end
    chk("t3_cnt8", cnt1, 8);
    chk("t3_rdy0", rdy1, 0);
    chk("t3_ovf_pre", ovf1, 0);
    byte1 = 8'hEE;
    tick();
    chk("t3_ovf", ovf1, 1);
    chk("t3_cnt_hold", cnt1, 8);
    byte1 = 8'hDD;
    tick();
    chk("t4_ovf", ovf1, 1);
    chk("t4_cnt7", cnt1, 7);
    chk("t4_rdy1", rdy1, 1);
    dv1 = 1'b0;
    tick();
    chk("t4_ovf_clr", ovf1, 0);
    for (int i = 0; i < 100; i++) tick();
    chk("t3_rx_n", rxq1.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < rxq1.size()) chk($sformatf("t3_rx%0d", i), rxq1[i], t3[i]);
    chk("t3_drain_cnt", cnt1, 0);
    chk("t3_drain_act", act1, 0);

    // 5: reset during data bit 3 of 0x5A
    rxq1.delete();
    dv1 = 1'b1; byte1 = 8'h5A;
    tick();
    byte1 = 8'h77;
    tick();
    byte1 = 8'h66;
    tick();
    dv1 = 1'b0;
    chk("t5_cnt2", cnt1, 2);
    tick();
    tick();
    chk("t5_bit2", ser1, 0);
    tick();
    chk("t5_bit3", ser1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ser", ser1, 1);
    chk("t5_act", act1, 0);
    chk("t5_cnt", cnt1, 0);
    chk("t5_done", done1, 0);
    tick();
    chk("t5_ser2", ser1, 1);
    chk("t5_act2", act1, 0);
    rxq1.delete();
    dv1 = 1'b1; byte1 = 8'h81;
    tick();
    dv1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t5_bit%0d", k), ser1, fbit(8'h81, k));
    end
    for (int i = 0; i < 5; i++) tick();
    chk("t5_ser_idle", ser1, 1);
    chk("t5_rx_n", rxq1.size(), 1);
    if (rxq1.size() == 1) chk("t5_rx0", rxq1[0], 8'h81);

    // 6: two stop bits, 0xC3
    rxq2.delete();
    dv2 = 1'b1; byte2 = 8'hC3;
    tick();
    dv2 = 1'b0;
    chk("t6_cnt1", cnt2, 1);
    for (int k = 0; k < 11; k++) begin
      tick();
      chk($sformatf("t6_bit%0d", k), ser2, fbit(8'hC3, k));
      chk($sformatf("t6_done%0d", k), done2, k == 10);
      chk($sformatf("t6_act%0d", k), act2, 1);
    end
    tick();
    chk("t6_after_act", act2, 0);
    chk("t6_after_ser", ser2, 1);
    chk("t6_after_done", done2, 0);
    tick(); tick();
    chk("t6_rx_n", rxq2.size(), 1);
    if (rxq2.size() == 1) chk("t6_rx0", rxq2[0], 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
